// File: rtl/vram_access_scheduler_if.sv
// ---------------------------------------------------------------------------
// vram_access_scheduler_if
//
// Bundles every non-clock signal of the display SRAM scheduler.
//   Timing  : FSn, Active, Load, AnG, AlphaRow, BaseAddr (from format timing)
//   CPU     : CpuReq/CpuWe/CpuAddr/CpuWData in, CpuAck/CpuRData out
//   SRAM    : MemAddr/MemWData/MemOe/MemWe out, MemRData in (asynchronous)
//   Video   : VidData/VidValid out, Overrun (sticky) out
//
// Handshakes:
//   CPU is a 4-phase request/acknowledge. The requester raises CpuReq with
//   CpuWe/CpuAddr/CpuWData stable, and keeps it high until CpuAck is seen.
//   CpuAck then stays high until CpuReq has been sampled low, and a new
//   request is not granted while CpuAck is high. Video has no back-pressure.
//   Each Load && Active requests one fetch, and VidValid pulses for one
//   cycle when VidData carries the fetched byte.
//
// The scheduler connects to the slave modport. The master modport is the
// view of the surrounding system (timing block, CPU and SRAM).
// ---------------------------------------------------------------------------
interface vram_access_scheduler_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              FSn;
    logic              Active;
    logic              Load;
    logic              AnG;
    logic [3:0]        AlphaRow;
    logic [ADDR_W-1:0] BaseAddr;
    logic              CpuReq;
    logic              CpuWe;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWData;
    logic              CpuAck;
    logic [DATA_W-1:0] CpuRData;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemOe;
    logic              MemWe;
    logic [DATA_W-1:0] MemRData;
    logic [DATA_W-1:0] VidData;
    logic              VidValid;
    logic              Overrun;

    modport slave (
        input  FSn, Active, Load, AnG, AlphaRow, BaseAddr,
        input  CpuReq, CpuWe, CpuAddr, CpuWData,
        output CpuAck, CpuRData,
        output MemAddr, MemWData, MemOe, MemWe,
        input  MemRData,
        output VidData, VidValid, Overrun
    );

    modport master (
        output FSn, Active, Load, AnG, AlphaRow, BaseAddr,
        output CpuReq, CpuWe, CpuAddr, CpuWData,
        input  CpuAck, CpuRData,
        input  MemAddr, MemWData, MemOe, MemWe,
        output MemRData,
        input  VidData, VidValid, Overrun
    );
endinterface

// File: rtl/vram_access_scheduler.sv
// ---------------------------------------------------------------------------
// vram_access_scheduler
//
// Shares one display SRAM between the video fetch path and CPU accesses.
// A video fetch (one SRAM cycle per Load && Active) always wins. The CPU
// gets the cycles that are left over. The block also generates the video
// read address, including the repeat of a character row in alpha mode.
//
// Ports:
//   Clk          pixel clock (the same clock that produces Load)
//   RSTn         asynchronous active-low reset
//   bus          vram_access_scheduler_if.slave (timing, CPU, SRAM, video)
//   dbg_state_o  current scheduler state (0 = IDLE, 1 = VID, 2 = CPU)
//
// All outputs are registered. SRAM controls are asserted only during the
// VID or CPU cycle itself. In IDLE, MemOe and MemWe are low, and MemAddr
// and MemWData hold their last value.
// ---------------------------------------------------------------------------
module vram_access_scheduler #(
    parameter int         ADDR_W         = 13,
    parameter int         DATA_W         = 8,
    parameter logic [3:0] ALPHA_LAST_ROW = 4'd11
) (
    input  logic                     Clk,
    input  logic                     RSTn,
    vram_access_scheduler_if.slave   bus,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              vid_pend_q, vid_pend_d;
    logic              overrun_q, overrun_d;
    logic              cpu_done_q, cpu_done_d;
    logic              active_q, active_d;
    logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
    logic [ADDR_W-1:0] line_start_q, line_start_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic              load_act;
    logic              line_end;
    logic              enter_vid;
    logic [ADDR_W-1:0] vid_addr_inc;

    always_comb begin
        load_act  = bus.Load && bus.Active;
        line_end  = active_q && !bus.Active;
        active_d  = bus.Active;

        // A fetch that finishes on this edge is counted before the line-end
        // rule runs, so that rule sees the incremented address.
        vid_addr_inc = (state_q == ST_VID) ? (vid_addr_q + ADDR_ONE) : vid_addr_q;

        vid_addr_d   = vid_addr_inc;
        line_start_d = line_start_q;
        if (!bus.FSn) begin
            vid_addr_d   = bus.BaseAddr;
            line_start_d = bus.BaseAddr;
        end else if (line_end) begin
            if (!bus.AnG && (bus.AlphaRow != ALPHA_LAST_ROW)) begin
                // Not the last scanline of a text row: fetch the same characters again.
                vid_addr_d = line_start_q;
            end else begin
                line_start_d = vid_addr_inc;
            end
        end

        // Scheduler. A Load seen in IDLE goes to VID at once (2-cycle latency).
        // A Load that arrives during a CPU cycle waits in vid_pend_q (3 cycles).
        state_d     = ST_IDLE;
        enter_vid   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_oe_d    = 1'b0;
        mem_we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vid_pend_q || load_act) begin
                    state_d    = ST_VID;
                    enter_vid  = 1'b1;
                    mem_addr_d = vid_addr_d;
                    mem_oe_d   = 1'b1;
                end else if (bus.CpuReq && !cpu_done_q) begin
                    state_d     = ST_CPU;
                    mem_addr_d  = bus.CpuAddr;
                    mem_wdata_d = bus.CpuWData;
                    mem_we_d    = bus.CpuWe;
                    mem_oe_d    = !bus.CpuWe;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering VID serves the pending fetch. A second Load on that same
        // edge is lost, and Overrun records it.
        vid_pend_d = vid_pend_q;
        if (!bus.FSn || enter_vid) begin
            vid_pend_d = 1'b0;
        end else if (load_act) begin
            vid_pend_d = 1'b1;
        end
        overrun_d = overrun_q || (load_act && vid_pend_q);

        vid_valid_d = (state_q == ST_VID);
        vid_data_d  = (state_q == ST_VID) ? bus.MemRData : vid_data_q;
        cpu_rdata_d = ((state_q == ST_CPU) && !mem_we_q) ? bus.MemRData : cpu_rdata_q;

        cpu_done_d = cpu_done_q;
        if (state_q == ST_CPU) begin
            cpu_done_d = 1'b1;
        end else if (!bus.CpuReq) begin
            cpu_done_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            vid_pend_q   <= 1'b0;
            overrun_q    <= 1'b0;
            cpu_done_q   <= 1'b0;
            active_q     <= 1'b0;
            vid_addr_q   <= '0;
            line_start_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_oe_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            vid_data_q   <= '0;
            vid_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            vid_pend_q   <= vid_pend_d;
            overrun_q    <= overrun_d;
            cpu_done_q   <= cpu_done_d;
            active_q     <= active_d;
            vid_addr_q   <= vid_addr_d;
            line_start_q <= line_start_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_oe_q     <= mem_oe_d;
            mem_we_q     <= mem_we_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign bus.CpuAck   = cpu_done_q;
    assign bus.CpuRData = cpu_rdata_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemWData = mem_wdata_q;
    assign bus.MemOe    = mem_oe_q;
    assign bus.MemWe    = mem_we_q;
    assign bus.VidData  = vid_data_q;
    assign bus.VidValid = vid_valid_q;
    assign bus.Overrun  = overrun_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vram_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vram_access_scheduler
//
// Drives timing and CPU traffic into the scheduler and models the SRAM.
// The reference model tracks the address each fetch should read: frame
// start, one increment per Load, and row repeat or advance at line end.
// It also keeps a copy of the memory contents. Expected fetches are queued
// when each Load is issued. A monitor pops them when the DUT shows a VID
// cycle (address check) and when VidValid is high (data and latency check).
// ---------------------------------------------------------------------------
module tb_vram_access_scheduler;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int MEM_N  = 1 << ADDR_W;
    localparam logic [1:0] DBG_IDLE = 2'd0;
    localparam logic [1:0] DBG_VID  = 2'd1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_access_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic [1:0] dbg_state;

    vram_access_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALPHA_LAST_ROW(4'd11)
    ) dut (
        .Clk(clk), .RSTn(rst_n), .bus(bus), .dbg_state_o(dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [DATA_W-1:0] sram    [0:MEM_N-1];
    logic [DATA_W-1:0] ref_mem [0:MEM_N-1];

    function automatic logic [7:0] pattern(input int a);
        logic [31:0] t;
        t = (a * 7) ^ (a >> 5);
        return t[7:0];
    endfunction

    assign bus.MemRData = sram[bus.MemAddr];

    initial begin
        for (int i = 0; i < MEM_N; i++) sram[i] = pattern(i);
        forever begin
            @(posedge clk);
            if (bus.MemWe) sram[bus.MemAddr] <= bus.MemWData;
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                exp_lat_q[$];
    int                load_cyc_q[$];
    int                want_lat = 2;   // 0 = either 2 or 3 cycles acceptable

    // Reference address model
    logic [ADDR_W-1:0] m_addr, m_line_start;

    function automatic void model_frame(input logic [ADDR_W-1:0] base);
        m_addr       = base;
        m_line_start = base;
    endfunction

    function automatic void model_load();
        exp_addr_q.push_back(m_addr);
        exp_q.push_back(ref_mem[m_addr]);
        exp_lat_q.push_back(want_lat);
        load_cyc_q.push_back(cyc);
        m_addr = m_addr + 1'b1;
    endfunction

    function automatic void model_line_end();
        if (!bus.AnG && bus.AlphaRow != 4'd11) m_addr = m_line_start;
        else m_line_start = m_addr;
    endfunction

    // Monitor
    logic [ADDR_W-1:0] mon_a;
    logic [DATA_W-1:0] mon_d;
    int                mon_lat, mon_lc;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dbg_state == DBG_VID) begin
                if (exp_addr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL vid_addr: unexpected fetch at %0h, none expected", bus.MemAddr);
                end else begin
                    mon_a = exp_addr_q.pop_front();
                    check("vid_addr", 32'(bus.MemAddr), 32'(mon_a));
                    check("vid_oe_we", {30'd0, bus.MemOe, bus.MemWe}, 32'd2);
                end
            end
            if (bus.VidValid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL vid_data: unexpected VidValid data %0h, none expected", bus.VidData);
                end else begin
                    mon_d   = exp_q.pop_front();
                    mon_lat = exp_lat_q.pop_front();
                    mon_lc  = load_cyc_q.pop_front();
                    check("vid_data", 32'(bus.VidData), 32'(mon_d));
                    if (mon_lat == 0)
                        check("vid_lat_range", 32'((cyc - mon_lc >= 2) && (cyc - mon_lc <= 3)), 32'd1);
                    else
                        check("vid_lat", 32'(cyc - mon_lc), 32'(mon_lat));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_line(input int n_loads);
        for (int c = 0; c < 128; c++) begin
            bus.Active = 1'b1;
            bus.Load   = ((c % 4) == 0) && ((c / 4) < n_loads);
            if (bus.Load) model_load();
            @(negedge clk);
        end
        bus.Active = 1'b0;
        bus.Load   = 1'b0;
        model_line_end();
        repeat (16) @(negedge clk);
    endtask

    task automatic frame_start(input logic [ADDR_W-1:0] base);
        bus.BaseAddr = base;
        bus.FSn      = 1'b0;
        repeat (3) @(negedge clk);
        bus.FSn = 1'b1;
        model_frame(base);
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        int n;
        bus.CpuReq   = 1'b1;
        bus.CpuWe    = we;
        bus.CpuAddr  = addr;
        bus.CpuWData = wd;
        n = 0;
        while (!bus.CpuAck && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("cpu_ack_bound", 32'(bus.CpuAck), 32'd1);
        if (we) ref_mem[addr] = wd;
        else check("cpu_rdata", 32'(bus.CpuRData), 32'(ref_mem[addr]));
        bus.CpuReq = 1'b0;
        @(negedge clk);
        check("cpu_ack_drop", 32'(bus.CpuAck), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_MemWe"},    32'(bus.MemWe),    32'd0);
        check({tag, "_MemOe"},    32'(bus.MemOe),    32'd0);
        check({tag, "_MemAddr"},  32'(bus.MemAddr),  32'd0);
        check({tag, "_MemWData"}, 32'(bus.MemWData), 32'd0);
        check({tag, "_CpuAck"},   32'(bus.CpuAck),   32'd0);
        check({tag, "_CpuRData"}, 32'(bus.CpuRData), 32'd0);
        check({tag, "_VidData"},  32'(bus.VidData),  32'd0);
        check({tag, "_VidValid"}, 32'(bus.VidValid), 32'd0);
        check({tag, "_Overrun"},  32'(bus.Overrun),  32'd0);
        check({tag, "_state"},    32'(dbg_state),    32'(DBG_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    bit stop_rand = 1'b0;

    initial begin
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = pattern(i);
        bus.FSn = 1'b1; bus.Active = 1'b0; bus.Load = 1'b0; bus.AnG = 1'b1;
        bus.AlphaRow = 4'd0; bus.BaseAddr = '0;
        bus.CpuReq = 1'b0; bus.CpuWe = 1'b0; bus.CpuAddr = '0; bus.CpuWData = '0;
        model_frame('0);

        // Power-on reset
        #1 rst_n = 1'b0;
        #2 check_all_zero("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPU write outside Active
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 13'h0010; bus.CpuWData = 8'h55;
        @(negedge clk);
        check("wr_we",     32'(bus.MemWe),    32'd1);
        check("wr_oe",     32'(bus.MemOe),    32'd0);
        check("wr_addr",   32'(bus.MemAddr),  32'h0010);
        check("wr_wdata",  32'(bus.MemWData), 32'h55);
        check("wr_ack_early", 32'(bus.CpuAck), 32'd0);
        @(negedge clk);
        check("wr_we_single", 32'(bus.MemWe), 32'd0);
        check("wr_ack",       32'(bus.CpuAck), 32'd1);
        ref_mem[13'h0010] = 8'h55;
        bus.CpuReq = 1'b0;
        @(negedge clk);
        check("wr_ack_drop", 32'(bus.CpuAck), 32'd0);
        @(negedge clk);

        // Reset in the middle of a write cycle
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 13'h0011; bus.CpuWData = 8'hAA;
        @(negedge clk);
        check("rst_pre_we", 32'(bus.MemWe), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        bus.CpuReq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_post_state", 32'(dbg_state), 32'(DBG_IDLE));
        check("rst_post_we",    32'(bus.MemWe), 32'd0);
        cpu_op(1'b0, 13'h0010, 8'h00);   // committed write survives
        cpu_op(1'b0, 13'h0011, 8'h00);   // aborted write left memory untouched

        // Graphics frame: two lines of 32 fetches from 0x0400
        want_lat = 2;
        bus.AnG = 1'b1; bus.AlphaRow = 4'd0;
        frame_start(13'h0400);
        repeat (2) drive_line(32);

        // Alpha mode: rows 0..11 repeat, the next character row advances
        bus.AnG = 1'b0;
        frame_start(13'h0400);
        for (int r = 0; r < 12; r++) begin
            bus.AlphaRow = 4'(r);
            drive_line(32);
        end
        bus.AlphaRow = 4'd0;
        drive_line(32);

        // Collision: CPU granted one cycle before Load
        bus.AnG = 1'b1;
        want_lat = 3;
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 13'h1234;
        @(negedge clk);
        bus.Active = 1'b1; bus.Load = 1'b1;
        model_load();
        @(negedge clk);
        bus.Load = 1'b0;
        check("col_ack",   32'(bus.CpuAck),   32'd1);
        check("col_rdata", 32'(bus.CpuRData), 32'(ref_mem[13'h1234]));
        bus.CpuReq = 1'b0;
        repeat (6) @(negedge clk);
        bus.Active = 1'b0;
        model_line_end();
        repeat (8) @(negedge clk);
        check("col_overrun", 32'(bus.Overrun), 32'd0);

        // Randomised lines with concurrent CPU traffic
        want_lat = 0;
        frame_start(13'($urandom_range(0, 'hC00)));
        fork
            begin
                for (int l = 0; l < 8; l++) begin
                    bus.AnG      = 1'($urandom_range(0, 1));
                    bus.AlphaRow = 4'($urandom_range(9, 11));
                    drive_line($urandom_range(1, 32));
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    cpu_op(1'($urandom_range(0, 1)), 13'h1000 + 13'($urandom_range(0, 15)),
                           8'($urandom_range(0, 255)));
                end
            end
        join
        check("rand_overrun", 32'(bus.Overrun), 32'd0);

        // Back-to-back Loads during a CPU access: second slot is lost
        want_lat = 3;
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 13'h1001;
        @(negedge clk);
        bus.Active = 1'b1; bus.Load = 1'b1;
        model_load();
        @(negedge clk);
        check("ovr_ack",   32'(bus.CpuAck),   32'd1);
        check("ovr_rdata", 32'(bus.CpuRData), 32'(ref_mem[13'h1001]));
        bus.CpuReq = 1'b0;
        @(negedge clk);
        bus.Load = 1'b0;
        check("ovr_set", 32'(bus.Overrun), 32'd1);
        repeat (10) @(negedge clk);
        bus.Active = 1'b0;
        model_line_end();
        repeat (10) @(negedge clk);
        check("ovr_sticky", 32'(bus.Overrun), 32'd1);

        // Drain the scoreboard
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        check("sb_data_empty", 32'(exp_q.size()),      32'd0);
        check("sb_addr_empty", 32'(exp_addr_q.size()), 32'd0);

        rst_n = 1'b0;
        #1 check("ovr_reset", 32'(bus.Overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
